// File: rtl/cp_copyblock_scheduler_pkg.sv
// Shared COPYBLOCK command definitions and scheduler state encoding.
package cp_copyblock_scheduler_pkg;

  // MCU COPYMEMBLOCK command word layout (64-bit).
  localparam int unsigned MCU_COPYMEMBLOCKCMD_SRC_LSB  = 0;
  localparam int unsigned MCU_COPYMEMBLOCKCMD_SRC_MSB  = 23;
  localparam int unsigned MCU_COPYMEMBLOCKCMD_DST_LSB  = 24;
  localparam int unsigned MCU_COPYMEMBLOCKCMD_DST_MSB  = 47;
  localparam int unsigned MCU_COPYMEMBLOCKCMD_LEN_LSB  = 48;
  localparam int unsigned MCU_COPYMEMBLOCKCMD_LEN_MSB  = 62;
  localparam int unsigned MCU_COPYMEMBLOCK_TAG_BIT     = 63;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBarrier
  } sched_state_e;

endpackage

// File: rtl/cp_cmd_fifo.sv
// Command FIFO: DEPTH x CMD_W, registered storage, flush clears all entries.
module cp_cmd_fifo #(
  parameter int unsigned CMD_W = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [CMD_W-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CMD_W-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cp_copyblock_scheduler.sv
// Issues queued COPYBLOCK commands to the MCU, limits outstanding copies and
// honours tagged commands as barriers that wait for all copies to finish.
module cp_copyblock_scheduler
  import cp_copyblock_scheduler_pkg::*;
#(
  parameter int unsigned CMD_W   = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iCmdValid,
  input  logic [CMD_W-1:0] iCmd,
  output logic             oCmdReady,
  output logic             oMcuReq,
  output logic [CMD_W-1:0] oMcuCmd,
  input  logic             iMcuAck,
  input  logic             iMcuDone,
  input  logic             iFlush,
  output logic             oIdle,
  output logic             oError
);

  localparam int unsigned OutW = $clog2(MAX_OUT + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUT);

  sched_state_e     state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [OutW-1:0]  out_q, out_d;
  logic             err_q, err_d;
  logic             held_q, held_d;

  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_head;
  logic             push, pop, ack_ok, dec;

  assign ack_ok = (state_q == StReq) && iMcuAck;
  assign push   = iCmdValid && oCmdReady && !iFlush;
  // Only pop if the presented entry still sits at the FIFO head (no flush since issue).
  assign pop    = ack_ok && held_q;
  assign dec    = iMcuDone && ((out_q != '0) || ack_ok);

  cp_cmd_fifo #(
    .CMD_W (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .push_i  (push),
    .data_i  (iCmd),
    .pop_i   (pop),
    .flush_i (iFlush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    held_d  = held_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty && (out_q < MaxOut) && !iFlush) begin
          state_d = StReq;
          cmd_d   = fifo_head;
          held_d  = 1'b1;
        end
      end
      StReq: begin
        if (iFlush) held_d = 1'b0;
        if (iMcuAck) begin
          held_d  = 1'b0;
          state_d = cmd_q[MCU_COPYMEMBLOCK_TAG_BIT] ? StBarrier : StIdle;
        end
      end
      StBarrier: begin
        if (out_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = out_q;
    case ({ack_ok, dec})
      2'b10:   out_d = out_q + OutW'(1);
      2'b01:   out_d = out_q - OutW'(1);
      default: out_d = out_q;
    endcase
    err_d = err_q | (iMcuDone && (out_q == '0) && !ack_ok);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      out_q   <= out_d;
      err_q   <= err_d;
      held_q  <= held_d;
    end
  end

  assign oCmdReady = !fifo_full;
  assign oMcuReq   = (state_q == StReq);
  assign oMcuCmd   = cmd_q;
  assign oIdle     = fifo_empty && (state_q != StReq) && (out_q == '0);
  assign oError    = err_q;

endmodule

// File: tb/tb_cp_copyblock_scheduler.sv
// Bench for cp_copyblock_scheduler: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_cp_copyblock_scheduler;
  import cp_copyblock_scheduler_pkg::*;

  localparam int CMD_W   = 64;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             iCmdValid, iMcuAck, iMcuDone, iFlush;
  logic [CMD_W-1:0] iCmd;
  logic             oCmdReady, oMcuReq, oIdle, oError;
  logic [CMD_W-1:0] oMcuCmd;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] mq[$];
  bit          m_pend, m_held, m_barrier, m_err, m_pushed;
  logic [63:0] m_cmd;
  int          m_out;

  cp_copyblock_scheduler #(
    .CMD_W   (CMD_W),
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iCmdValid (iCmdValid),
    .iCmd      (iCmd),
    .oCmdReady (oCmdReady),
    .oMcuReq   (oMcuReq),
    .oMcuCmd   (oMcuCmd),
    .iMcuAck   (iMcuAck),
    .iMcuDone  (iMcuDone),
    .iFlush    (iFlush),
    .oIdle     (oIdle),
    .oError    (oError)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_held = 0; m_barrier = 0; m_err = 0; m_pushed = 0;
    m_cmd = '0; m_out = 0;
  endtask

  // One clock of the reference behaviour, all decisions from pre-edge state.
  task automatic model_step(input bit v, input logic [63:0] c, input bit ack, input bit done,
                            input bit flush);
    int          old_out;
    int          old_sz;
    bit          ack_ok;
    bit          issue;
    logic [63:0] head;
    old_out = m_out;
    old_sz  = mq.size();
    ack_ok  = m_pend && ack;
    issue   = !m_pend && !m_barrier && old_sz > 0 && old_out < MAX_OUT && !flush;
    head    = (old_sz > 0) ? mq[0] : 64'd0;
    if (m_barrier && old_out == 0) m_barrier = 0;
    if (done && old_out == 0 && !ack_ok) m_err = 1;
    if (ack_ok && !done) m_out = m_out + 1;
    else if (!ack_ok && done && old_out > 0) m_out = m_out - 1;
    m_pushed = v && old_sz < DEPTH && !flush;
    if (flush) begin
      mq.delete();
      m_held = 0;
    end else begin
      if (ack_ok && m_held) void'(mq.pop_front());
      if (m_pushed) mq.push_back(c);
    end
    if (ack_ok) begin
      m_pend = 0;
      m_held = 0;
      if (m_cmd[MCU_COPYMEMBLOCK_TAG_BIT]) m_barrier = 1;
    end
    if (issue) begin
      m_pend = 1;
      m_cmd  = head;
      m_held = 1;
    end
  endtask

  task automatic check_all();
    chk("ready", 64'(oCmdReady), 64'(mq.size() < DEPTH));
    chk("req",   64'(oMcuReq),   64'(m_pend));
    chk("cmd",   oMcuCmd,        m_cmd);
    chk("idle",  64'(oIdle),     64'(mq.size() == 0 && !m_pend && m_out == 0));
    chk("error", 64'(oError),    64'(m_err));
  endtask

  task automatic cyc(input bit v, input logic [63:0] c, input bit ack, input bit done,
                     input bit flush);
    iCmdValid = v; iCmd = c; iMcuAck = ack; iMcuDone = done; iFlush = flush;
    @(posedge Clock);
    model_step(v, c, ack, done, flush);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 64'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    iCmdValid = 0; iCmd = '0; iMcuAck = 0; iMcuDone = 0; iFlush = 0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
  endtask

  // Behave as a well-mannered MCU until everything has drained.
  task automatic drain();
    bit finished = 0;
    for (int i = 0; i < 300 && !finished; i++) begin
      cyc(0, 64'd0, m_pend, (m_out > 0), 0);
      finished = (mq.size() == 0 && !m_pend && m_out == 0);
    end
    checks++;
    assert (finished) else begin
      errors++;
      $error("FAIL drain_timeout observed busy expected idle within 300 cycles");
    end
  endtask

  function automatic logic [63:0] rnd_cmd(input bit tag);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[MCU_COPYMEMBLOCK_TAG_BIT] = tag;
    return r;
  endfunction

  initial begin
    logic [63:0] c, c5, t, u;
    bit          accepted;

    // Reset values
    do_reset();
    #1;
    chk("rst_ready", 64'(oCmdReady), 64'd1);
    chk("rst_req",   64'(oMcuReq),   64'd0);
    chk("rst_cmd",   oMcuCmd,        64'd0);
    chk("rst_idle",  64'(oIdle),     64'd1);
    chk("rst_err",   64'(oError),    64'd0);

    // Single untagged command: two-cycle request latency, idle one cycle after done
    idle(8);
    c = rnd_cmd(0);
    cyc(1, c, 0, 0, 0);
    chk("lat_n1", 64'(oMcuReq), 64'd0);
    cyc(0, 64'd0, 0, 0, 0);
    chk("lat_n2", 64'(oMcuReq), 64'd1);
    chk("lat_cmd", oMcuCmd, c);
    cyc(0, 64'd0, 1, 0, 0);
    chk("ack_drop", 64'(oMcuReq), 64'd0);
    chk("ack_busy", 64'(oIdle), 64'd0);
    idle(4);
    cyc(0, 64'd0, 0, 1, 0);
    chk("idle_after_done", 64'(oIdle), 64'd1);

    // Five back-to-back pushes into a four-entry FIFO with the ack withheld
    for (int i = 0; i < 4; i++) cyc(1, rnd_cmd(0), 0, 0, 0);
    chk("full_ready", 64'(oCmdReady), 64'd0);
    c5 = rnd_cmd(0);
    cyc(1, c5, 0, 0, 0);
    cyc(1, c5, 0, 0, 0);
    chk("stall5", 64'(oCmdReady), 64'd0);
    cyc(1, c5, 1, 0, 0);
    chk("ready_after_ack", 64'(oCmdReady), 64'd1);
    accepted = 0;
    for (int i = 0; i < 4 && !accepted; i++) begin
      cyc(1, c5, 0, 0, 0);
      accepted = m_pushed;
    end
    chk("fifth_accepted_full", 64'(oCmdReady), 64'd0);
    drain();

    // Outstanding limit: third command waits for the first done
    for (int i = 0; i < 3; i++) cyc(1, rnd_cmd(0), m_pend, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 64'd0, m_pend, 0, 0);
    chk("max_out_hold", 64'(oMcuReq), 64'd0);
    chk("max_out_busy", 64'(oIdle), 64'd0);
    cyc(0, 64'd0, 0, 1, 0);
    cyc(0, 64'd0, 0, 0, 0);
    chk("third_req", 64'(oMcuReq), 64'd1);
    drain();

    // Tagged command acts as a barrier for the following command
    t = rnd_cmd(1);
    u = rnd_cmd(0);
    cyc(1, t, 0, 0, 0);
    cyc(1, u, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 64'd0, m_pend, 0, 0);
    chk("barrier_hold", 64'(oMcuReq), 64'd0);
    cyc(0, 64'd0, 0, 1, 0);
    cyc(0, 64'd0, 0, 0, 0);
    chk("barrier_still", 64'(oMcuReq), 64'd0);
    cyc(0, 64'd0, 0, 0, 0);
    chk("after_barrier", 64'(oMcuReq), 64'd1);
    chk("after_barrier_cmd", oMcuCmd, u);
    drain();

    // Flush during a request: presented command survives, queue and same-cycle push dropped
    c = rnd_cmd(0);
    cyc(1, c, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, rnd_cmd(0), 0, 0, 0);
    chk("flush_pre_req", 64'(oMcuReq), 64'd1);
    cyc(1, rnd_cmd(0), 0, 0, 1);
    chk("flush_req_kept", 64'(oMcuReq), 64'd1);
    chk("flush_cmd_kept", oMcuCmd, c);
    chk("flush_ready", 64'(oCmdReady), 64'd1);
    cyc(0, 64'd0, 1, 0, 0);
    idle(3);
    chk("post_flush_noreq", 64'(oMcuReq), 64'd0);
    chk("post_flush_busy", 64'(oIdle), 64'd0);
    cyc(0, 64'd0, 0, 1, 0);
    chk("post_flush_idle", 64'(oIdle), 64'd1);

    // Spurious done sets sticky error; async reset clears it and drops the request
    cyc(0, 64'd0, 0, 1, 0);
    chk("err_set", 64'(oError), 64'd1);
    idle(3);
    chk("err_held", 64'(oError), 64'd1);
    cyc(1, rnd_cmd(0), 0, 0, 0);
    cyc(0, 64'd0, 0, 0, 0);
    chk("pre_rst_req", 64'(oMcuReq), 64'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_req_drop", 64'(oMcuReq), 64'd0);
    chk("async_err_clr",  64'(oError),  64'd0);
    chk("async_idle",     64'(oIdle),   64'd1);
    chk("async_cmd_clr",  oMcuCmd,      64'd0);
    do_reset();

    // Random traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 9) < 6), rnd_cmd($urandom_range(0, 4) == 0),
          $urandom_range(0, 1) == 1, (m_out > 0) && ($urandom_range(0, 9) < 3),
          $urandom_range(0, 39) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
